gpio_wide: RTL and testbench

Parametrised Wishbone GPIO controller with an 8-bit data bus and an arbitrary pin count. It supports per-pin direction, a two-flop input synchronizer and per-pin edge-triggered interrupts with sticky, write-1-to-clear status. It sits on the peripheral Wishbone bus next to the UART and SPI slaves and drives board pads plus one level interrupt line to the PIC. It replaces the fixed 8-bit GPIO, whose registers had to be widened by hand.

---
 rtl/gpio_wide.sv | 136 +++++++++++++
 tb/tb_gpio_wide.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_wide.sv
// Wishbone GPIO controller: 8-bit bus, GPIO_WIDTH pins in byte-addressed banks
// (DATA, DIR, IEN, IEDGE, ISTAT). Edge interrupts exist only with GPIO_IRQ_EN defined.
module gpio_wide #(
    parameter int                    GPIO_WIDTH     = 8,
    parameter int                    WB_ADR_WIDTH   = 4,
    parameter logic [GPIO_WIDTH-1:0] GPIO_DIR_RESET = '0,
    parameter logic [GPIO_WIDTH-1:0] GPIO_O_RESET   = '0
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
    input  logic [7:0]              wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [7:0]              wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    inout  wire  [GPIO_WIDTH-1:0]   gpio_io,
    output logic                    irq_o
);

    localparam int NB    = (GPIO_WIDTH + 7) / 8;
    localparam int PW    = NB * 8;
    localparam int NBANK = 5;

    logic [GPIO_WIDTH-1:0]        out_r, dir_r, sync1, sync2, in_val;
    logic [NBANK-1:0][NB-1:0]     wr_sel;
    logic [NBANK-1:0][PW-1:0]     rd_bank;
    logic [7:0]                   rd_byte;
    logic                         req, wr_req;
    logic                         unused_bus;

    // Burst type and cycle tags are ignored: every access is a classic cycle.
    assign unused_bus = ^{wb_cti_i, wb_bte_i};
    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;

    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_req = req & wb_we_i;
    assign in_val = (dir_r & out_r) | (~dir_r & sync2);

    // Replace the bytes of cur selected by sel; bits beyond the pin count drop out.
    function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] cur,
                                                    input logic [NB-1:0]         sel,
                                                    input logic [7:0]            d);
        merge = cur;
        for (int i = 0; i < GPIO_WIDTH; i++)
            if (sel[i/8]) merge[i] = d[i%8];
    endfunction

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_sel  = '0;
        rd_byte = '0;
        for (int k = 0; k < NBANK; k++)
            for (int j = 0; j < NB; j++)
                if (32'(wb_adr_i) == k * NB + j) begin
                    wr_sel[k][j] = wr_req;
                    rd_byte      = rd_bank[k][8*j +: 8];
                end
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
        assign gpio_io[i] = dir_r[i] ? out_r[i] : 1'bz;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            out_r    <= GPIO_O_RESET;
            dir_r    <= GPIO_DIR_RESET;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) wb_dat_o <= rd_byte;
            out_r    <= merge(out_r, wr_sel[0], wb_dat_i);
            dir_r    <= merge(dir_r, wr_sel[1], wb_dat_i);
            sync1    <= gpio_io;
            sync2    <= sync1;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] ien, iedge, istat, prev, rise, fall, hit, clr;

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;
    // Output pins never raise status; IEN only gates the interrupt line.
    assign hit  = ((iedge & rise) | (~iedge & fall)) & ~dir_r;
    assign clr  = merge('0, wr_sel[4], wb_dat_i);

    always_comb begin
        rd_bank    = '0;
        rd_bank[0] = PW'(in_val);
        rd_bank[1] = PW'(dir_r);
        rd_bank[2] = PW'(ien);
        rd_bank[3] = PW'(iedge);
        rd_bank[4] = PW'(istat);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ien   <= '0;
            iedge <= '0;
            istat <= '0;
            prev  <= '0;
            irq_o <= 1'b0;
        end else begin
            ien   <= merge(ien, wr_sel[2], wb_dat_i);
            iedge <= merge(iedge, wr_sel[3], wb_dat_i);
            istat <= (istat & ~clr) | hit;
            prev  <= sync2;
            irq_o <= |(istat & ien);
        end
    end
`else
    logic unused_sel;

    assign unused_sel = ^wr_sel[4:2];
    assign irq_o      = 1'b0;

    always_comb begin
        rd_bank    = '0;
        rd_bank[0] = PW'(in_val);
        rd_bank[1] = PW'(dir_r);
    end
`endif

endmodule

// File: tb/tb_gpio_wide.sv
// Self-checking bench for gpio_wide (12 pins, 4 address bits): directed table,
// hand-written corner sequences and random traffic against a bank-level model.
module tb_gpio_wide;

    localparam int W  = 12;
    localparam int NB = 2;
    localparam int AW = 4;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic [AW-1:0] adr_i = '0;
    logic [7:0]    dat_i = '0;
    logic          we_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0;
    logic [2:0]    cti_i = 3'd0;
    logic [1:0]    bte_i = 2'd0;
    logic [7:0]    wb_dat_o;
    logic          wb_ack_o, wb_err_o, wb_rty_o, irq_o;
    wire  [W-1:0]  gpio_io;
    logic [W-1:0]  tb_pad = '0;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    always #5 wb_clk = ~wb_clk;

    gpio_wide #(
        .GPIO_WIDTH(W), .WB_ADR_WIDTH(AW),
        .GPIO_DIR_RESET(12'h000), .GPIO_O_RESET(12'h000)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(adr_i), .wb_dat_i(dat_i),
        .wb_we_i(we_i), .wb_cyc_i(cyc_i), .wb_stb_i(stb_i), .wb_cti_i(cti_i),
        .wb_bte_i(bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .gpio_io(gpio_io), .irq_o(irq_o)
    );

    // Reference model: register banks as plain vectors, pad history as a 3-deep list.
    logic [W-1:0] m_out, m_dir, m_ien, m_iedge, m_istat;
    logic [W-1:0] hist [3];
    logic         m_ack, m_rd, m_irq;
    logic [7:0]   m_dat;
    logic [W-1:0] pad_now, hit, clr;
    logic         acc, irq_next;
    int           a_m;

    // The bench drives every pad the model says is an input.
    for (genvar i = 0; i < W; i++) begin : g_drv
        assign gpio_io[i] = m_dir[i] ? 1'bz : tb_pad[i];
    end

    function automatic logic [W-1:0] bank_val(input int b);
        case (b)
            0: return (m_dir & m_out) | (~m_dir & hist[1]);
            1: return m_dir;
`ifdef GPIO_IRQ_EN
            2: return m_ien;
            3: return m_iedge;
            4: return m_istat;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic [7:0] mread(input int a);
        int v;
        if (a >= 5 * NB) return 8'h00;
        v = int'(bank_val(a / NB));
        return 8'((v >> (8 * (a % NB))) & 255);
    endfunction

    function automatic logic [W-1:0] mwrite(input logic [W-1:0] cur, input int bi, input logic [7:0] d);
        int mask, v;
        mask = 255 << (8 * bi);
        v    = (int'(cur) & ~mask) | (int'(d) << (8 * bi));
        return W'(v);
    endfunction

    always @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            m_out = '0; m_dir = '0; m_ien = '0; m_iedge = '0; m_istat = '0;
            m_ack = 1'b0; m_rd = 1'b0; m_irq = 1'b0; m_dat = '0;
            for (int i = 0; i < 3; i++) hist[i] = '0;
        end else begin
            acc      = cyc_i & stb_i & ~m_ack;
            a_m      = int'(adr_i);
            pad_now  = (m_dir & m_out) | (~m_dir & tb_pad);
            hit      = ((m_iedge & hist[1] & ~hist[2]) | (~m_iedge & ~hist[1] & hist[2])) & ~m_dir;
            irq_next = |(m_istat & m_ien);
            clr      = '0;
            m_rd     = acc & ~we_i;
            if (acc) begin
                m_dat = mread(a_m);
                if (we_i && a_m < 5 * NB)
                    case (a_m / NB)
                        0: m_out = mwrite(m_out, a_m % NB, dat_i);
                        1: m_dir = mwrite(m_dir, a_m % NB, dat_i);
`ifdef GPIO_IRQ_EN
                        2: m_ien   = mwrite(m_ien, a_m % NB, dat_i);
                        3: m_iedge = mwrite(m_iedge, a_m % NB, dat_i);
                        4: clr     = mwrite('0, a_m % NB, dat_i);
`endif
                        default: ;
                    endcase
            end
`ifdef GPIO_IRQ_EN
            m_istat = (m_istat & ~clr) | hit;
            m_irq   = irq_next;
`endif
            m_ack   = acc;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pad_now;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge wb_clk) begin
        if (wb_rst_n && mon_en) begin
            check("mon_ack", 16'(wb_ack_o), 16'(m_ack));
            if (m_ack && m_rd) check("mon_rdata", 16'(wb_dat_o), 16'(m_dat));
            check("mon_irq", 16'(irq_o), 16'(m_irq));
            check("mon_pads", 16'(gpio_io & m_dir), 16'(m_out & m_dir));
        end
    end

    // Called at a falling edge; returns at a falling edge with the bus idle again.
    task automatic bus(input logic we, input int a, input logic [7:0] d, output logic [7:0] rd);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = AW'(a); dat_i = d;
        @(negedge wb_clk);
        check("bus_ack", 16'(wb_ack_o), 16'h0001);
        rd = wb_dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        logic [7:0] rd;
        bus(1'b1, a, d, rd);
    endtask

    task automatic rdchk(input string name, input int a, input logic [7:0] exp);
        logic [7:0] rd;
        bus(1'b0, a, 8'h00, rd);
        check(name, 16'(rd), 16'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    typedef struct {
        logic       we;
        int         adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        tbl[0] = '{1'b1, 2,  8'hFF, 8'h00};
        tbl[1] = '{1'b1, 3,  8'h0F, 8'h00};
        tbl[2] = '{1'b1, 0,  8'hA5, 8'h00};
        tbl[3] = '{1'b1, 1,  8'hFC, 8'h00};
        tbl[4] = '{1'b0, 1,  8'h00, 8'h0C};
        tbl[5] = '{1'b0, 0,  8'h00, 8'hA5};
        tbl[6] = '{1'b0, 3,  8'h00, 8'h0F};
        tbl[7] = '{1'b0, 2,  8'h00, 8'hFF};
        tbl[8] = '{1'b0, 15, 8'h00, 8'h00};
        tbl[9] = '{1'b0, 10, 8'h00, 8'h00};

        repeat (3) @(negedge wb_clk);
        check("rst_ack", 16'(wb_ack_o), 16'h0000);
        check("rst_dat", 16'(wb_dat_o), 16'h0000);
        check("rst_irq", 16'(irq_o), 16'h0000);
        check("rst_err_rty", 16'({wb_err_o, wb_rty_o}), 16'h0000);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        mon_en = 1'b1;
        rdchk("rst_dir0", 2, 8'h00);
        rdchk("rst_dir1", 3, 8'h00);

        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, rd);
            if (!tbl[i].we) check($sformatf("tbl_%0d_adr%0d", i, tbl[i].adr), 16'(rd), 16'(tbl[i].exp));
        end
        check("pads_cA5", 16'(gpio_io), 16'h0CA5);

        // Back to all inputs, then the two-flop synchronizer latency.
        wr(2, 8'h00); wr(3, 8'h00);
        idle(3);
        tb_pad[9] = 1'b1;
        idle(2);
        rdchk("sync_pad9", 1, 8'h02);
        rdchk("oob_adr10", 10, 8'h00);

`ifdef GPIO_IRQ_EN
        // Rising-edge interrupt and W1C.
        wr(8, 8'hFF); wr(9, 8'hFF);
        wr(6, 8'h01); wr(4, 8'h01);
        tb_pad[0] = 1'b1;
        idle(4);
        check("rise_irq", 16'(irq_o), 16'h0001);
        rdchk("rise_istat", 8, 8'h01);
        wr(8, 8'h01);
        check("w1c_irq_low", 16'(irq_o), 16'h0000);
        rdchk("w1c_istat", 8, 8'h00);

        // Falling edge captured with IEN off, then unmasked.
        wr(6, 8'h00); wr(4, 8'h00);
        tb_pad[3] = 1'b1;
        idle(4);
        wr(8, 8'hFF);
        tb_pad[3] = 1'b0;
        idle(4);
        rdchk("fall_istat", 8, 8'h08);
        check("fall_masked_irq", 16'(irq_o), 16'h0000);
        wr(4, 8'h08);
        check("unmask_irq", 16'(irq_o), 16'h0001);

        // Status set lands on the same edge as a W1C of that bit: set wins.
        wr(4, 8'h00); wr(6, 8'h01);
        tb_pad[0] = 1'b0;
        idle(4);
        wr(8, 8'hFF);
        tb_pad[0] = 1'b1;
        idle(2);
        wr(8, 8'h01);
        rdchk("collide_istat", 8, 8'h01);

        // Output pins do not raise status.
        wr(8, 8'hFF); wr(6, 8'h03); wr(2, 8'h02);
        wr(0, 8'h02); wr(0, 8'h00); wr(0, 8'h02);
        idle(4);
        rdchk("outpin_istat", 8, 8'h00);

        // Async reset in the middle of an access.
        wr(2, 8'h00); wr(6, 8'h00);
        idle(4);
        wr(8, 8'hFF);
        tb_pad[0] = 1'b0;
        idle(4);
        wr(4, 8'h01);
        check("pre_rst_irq", 16'(irq_o), 16'h0001);
`else
        wr(4, 8'hFF); wr(6, 8'hFF); wr(8, 8'hFF);
        rdchk("noirq_ien", 4, 8'h00);
        rdchk("noirq_iedge", 6, 8'h00);
        tb_pad[0] = 1'b1;
        idle(4);
        rdchk("noirq_istat", 8, 8'h00);
        check("noirq_irq", 16'(irq_o), 16'h0000);
`endif
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = AW'(8);
        @(posedge wb_clk);
        #1;
        check("mid_ack_high", 16'(wb_ack_o), 16'h0001);
        wb_rst_n = 1'b0;
        #1;
        check("async_ack", 16'(wb_ack_o), 16'h0000);
        check("async_irq", 16'(irq_o), 16'h0000);
        cyc_i = 1'b0; stb_i = 1'b0;
        idle(2);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        rdchk("post_rst_istat", 8, 8'h00);
        rdchk("post_rst_ien", 4, 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tb_pad = W'($urandom);
                idle(int'($urandom_range(1, 4)));
            end else begin
                bus(1'($urandom), int'($urandom_range(0, 15)), 8'($urandom), rd);
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
